// File: rtl/imsic_msi_tx_axi.sv
// AXI4-lite write master delivering MSIs to IMSIC interrupt files.
// Requests {hart, eiid} are queued in a small FIFO. Each one becomes a single
// AXI write to BASE_ADDR + hart*4KiB with data = eiid. Only one write is
// outstanding at a time, and a bad B response is reported with the hart index.
module imsic_msi_tx_axi #(
  parameter int                        AXI_ID_WIDTH   = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        HART_IDX_WIDTH = 4,
  parameter int                        FIFO_DEPTH     = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h2400_0000),
  parameter logic [AXI_ID_WIDTH-1:0]   TX_AXI_ID      = '0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [HART_IDX_WIDTH-1:0] req_hart,
  input  logic [10:0]               req_eiid,
  output logic                      awvalid_m,
  input  logic                      awready_m,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr_m,
  output logic [AXI_ID_WIDTH-1:0]   awid_m,
  output logic                      wvalid_m,
  input  logic                      wready_m,
  output logic [31:0]               wdata_m,
  input  logic                      bvalid_m,
  output logic                      bready_m,
  input  logic [AXI_ID_WIDTH-1:0]   bid_m,
  input  logic [1:0]                bresp_m,
  output logic                      err_vld,
  output logic [HART_IDX_WIDTH-1:0] err_hart,
  output logic                      busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [HART_IDX_WIDTH-1:0] hart;
    logic [10:0]               eiid;
  } req_t;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  req_t                      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  state_t                    state;
  logic [HART_IDX_WIDTH-1:0] cur_hart;

  logic                      push, pop, aw_ok, w_ok, b_bad;
  req_t                      head;
  logic [AXI_ADDR_WIDTH-1:0] hart_ext;

  assign req_rdy  = (count != CNT_W'(FIFO_DEPTH));
  // EIID 0 is not a valid identity: such requests are handshaked but never stored
  assign push     = req_vld & req_rdy & (req_eiid != 11'd0);
  assign pop      = (state == IDLE) & (count != '0);
  assign head     = mem[rd_ptr];
  assign hart_ext = AXI_ADDR_WIDTH'(head.hart);
  // A channel is finished once its valid has dropped or is handshaking now
  assign aw_ok    = ~awvalid_m | awready_m;
  assign w_ok     = ~wvalid_m | wready_m;
  assign b_bad    = (bresp_m != 2'b00) | (bid_m != TX_AXI_ID);
  assign awid_m   = TX_AXI_ID;
  assign busy     = (state != IDLE) | (count != '0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{hart: req_hart, eiid: req_eiid};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transaction FSM with registered AXI and error outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      awvalid_m <= 1'b0;
      wvalid_m  <= 1'b0;
      bready_m  <= 1'b0;
      awaddr_m  <= '0;
      wdata_m   <= '0;
      cur_hart  <= '0;
      err_vld   <= 1'b0;
      err_hart  <= '0;
    end else begin
      err_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            awaddr_m  <= BASE_ADDR + (hart_ext << 12);
            wdata_m   <= {21'b0, head.eiid};
            cur_hart  <= head.hart;
            awvalid_m <= 1'b1;
            wvalid_m  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (awvalid_m & awready_m) awvalid_m <= 1'b0;
          if (wvalid_m & wready_m)   wvalid_m  <= 1'b0;
          if (aw_ok & w_ok) begin
            bready_m <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (bvalid_m) begin
            bready_m <= 1'b0;
            state    <= IDLE;
            if (b_bad) begin
              err_vld  <= 1'b1;
              err_hart <= cur_hart;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imsic_msi_tx_axi.sv
// Directed bench for imsic_msi_tx_axi: latency, back-pressure, FIFO fill,
// error reporting, EIID-0 drop and reset in the middle of a transaction.
module tb_imsic_msi_tx_axi;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  req_hart;
  logic [10:0] req_eiid;
  logic        awvalid_m, awready_m;
  logic [31:0] awaddr_m;
  logic [31:0] awid_m;
  logic        wvalid_m, wready_m;
  logic [31:0] wdata_m;
  logic        bvalid_m, bready_m;
  logic [31:0] bid_m;
  logic [1:0]  bresp_m;
  logic        err_vld;
  logic [3:0]  err_hart;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  imsic_msi_tx_axi dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_hart(req_hart), .req_eiid(req_eiid),
    .awvalid_m(awvalid_m), .awready_m(awready_m), .awaddr_m(awaddr_m), .awid_m(awid_m),
    .wvalid_m(wvalid_m), .wready_m(wready_m), .wdata_m(wdata_m),
    .bvalid_m(bvalid_m), .bready_m(bready_m), .bid_m(bid_m), .bresp_m(bresp_m),
    .err_vld(err_vld), .err_hart(err_hart), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] h, input logic [10:0] e);
    req_vld = 1'b1; req_hart = h; req_eiid = e;
    tick();
    req_vld = 1'b0; req_hart = '0; req_eiid = '0;
  endtask

  task automatic b_resp(input logic [31:0] id, input logic [1:0] resp);
    bvalid_m = 1'b1; bid_m = id; bresp_m = resp;
    tick();
    bvalid_m = 1'b0; bid_m = '0; bresp_m = 2'b00;
  endtask

  task automatic wait_bready();
    for (int t = 0; t < 20 && !bready_m; t++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_vld = 0; req_hart = 0; req_eiid = 0;
    awready_m = 1; wready_m = 1; bvalid_m = 0; bid_m = 0; bresp_m = 0;
    #12;
    n_cmp++; if ({awvalid_m, wvalid_m, bready_m, err_vld, busy} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl got %b want 00000", {awvalid_m, wvalid_m, bready_m, err_vld, busy}); end
    n_cmp++; if ({awaddr_m, wdata_m, err_hart} !== 68'h0) begin n_bad++; $display("FAIL reset_data got %h %h %h want 0", awaddr_m, wdata_m, err_hart); end
    n_cmp++; if (req_rdy !== 1'b1 || awid_m !== 32'h0) begin n_bad++; $display("FAIL reset_rdy_id got rdy=%b id=%h want 1 0", req_rdy, awid_m); end
    @(posedge clk); #1; rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push(4'd3, 11'd5);
    n_cmp++; if (awvalid_m !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_n1 got awv=%b busy=%b want 0 1", awvalid_m, busy); end
    tick();
    n_cmp++; if (awvalid_m !== 1'b1 || wvalid_m !== 1'b1 || bready_m !== 1'b0) begin n_bad++; $display("FAIL single_n2 got awv=%b wv=%b br=%b want 1 1 0", awvalid_m, wvalid_m, bready_m); end
    n_cmp++; if (awaddr_m !== 32'h2400_3000 || wdata_m !== 32'h5) begin n_bad++; $display("FAIL single_data got %h %h want 24003000 00000005", awaddr_m, wdata_m); end
    tick();
    n_cmp++; if (awvalid_m !== 1'b0 || wvalid_m !== 1'b0 || bready_m !== 1'b1) begin n_bad++; $display("FAIL single_resp got awv=%b wv=%b br=%b want 0 0 1", awvalid_m, wvalid_m, bready_m); end
    b_resp(32'h0, 2'b00);
    n_cmp++; if (err_vld !== 1'b0 || bready_m !== 1'b0) begin n_bad++; $display("FAIL single_b got err=%b br=%b want 0 0", err_vld, bready_m); end
    tick();
    n_cmp++; if (busy !== 1'b0 || err_vld !== 1'b0) begin n_bad++; $display("FAIL single_idle got busy=%b err=%b want 0 0", busy, err_vld); end
  endtask

  task automatic test_backpressure();
    // AW delayed, W immediate, then the reverse
    for (int s = 0; s < 2; s++) begin
      logic [31:0] exp_addr;
      exp_addr = 32'h2400_0000 + (32'(s + 1) << 12);
      awready_m = (s == 1); wready_m = (s == 0);
      push(4'(s + 1), 11'(s + 2));
      tick();
      n_cmp++; if (awvalid_m !== 1'b1 || wvalid_m !== 1'b1) begin n_bad++; $display("FAIL bp%0d_start got awv=%b wv=%b want 1 1", s, awvalid_m, wvalid_m); end
      for (int c = 0; c < 2; c++) begin
        tick();
        n_cmp++;
        if ((s == 0 && (awvalid_m !== 1'b1 || wvalid_m !== 1'b0)) || (s == 1 && (awvalid_m !== 1'b0 || wvalid_m !== 1'b1)) ||
            bready_m !== 1'b0 || awaddr_m !== exp_addr || wdata_m !== 32'(s + 2)) begin
          n_bad++; $display("FAIL bp%0d_hold got awv=%b wv=%b br=%b addr=%h data=%h want addr=%h", s, awvalid_m, wvalid_m, bready_m, awaddr_m, wdata_m, exp_addr);
        end
      end
      awready_m = 1'b1; wready_m = 1'b1;
      tick();
      n_cmp++; if (awvalid_m !== 1'b0 || wvalid_m !== 1'b0 || bready_m !== 1'b1) begin n_bad++; $display("FAIL bp%0d_done got awv=%b wv=%b br=%b want 0 0 1", s, awvalid_m, wvalid_m, bready_m); end
      b_resp(32'h0, 2'b00);
      tick();
    end
  endtask

  task automatic test_fifo_fill();
    awready_m = 1'b0; wready_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy%0d got %b want 1", k, req_rdy); end
      push(4'(k), 11'(k + 1));
    end
    // sixth push must be refused while the FIFO is full
    req_vld = 1'b1; req_hart = 4'd5; req_eiid = 11'd6;
    n_cmp++; if (req_rdy !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL fill_full got rdy=%b busy=%b want 0 1", req_rdy, busy); end
    tick();
    req_vld = 1'b0; req_hart = '0; req_eiid = '0;
    awready_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 20 && !awvalid_m; t++) tick();
      n_cmp++; if (awvalid_m !== 1'b1 || awaddr_m !== 32'h2400_0000 + (32'(k) << 12) || wdata_m !== 32'(k + 1)) begin
        n_bad++; $display("FAIL fill_wr%0d got awv=%b addr=%h data=%h want 1 %h %h", k, awvalid_m, awaddr_m, wdata_m, 32'h2400_0000 + (32'(k) << 12), k + 1);
      end
      wait_bready();
      n_cmp++; if (bready_m !== 1'b1 || awvalid_m !== 1'b0) begin n_bad++; $display("FAIL fill_out%0d got br=%b awv=%b want 1 0", k, bready_m, awvalid_m); end
      tick();
      n_cmp++; if (awvalid_m !== 1'b0) begin n_bad++; $display("FAIL fill_one%0d got awv=%b want 0", k, awvalid_m); end
      b_resp(32'h0, 2'b00);
    end
    tick(); tick();
    n_cmp++; if (awvalid_m !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL fill_end got awv=%b busy=%b want 0 0", awvalid_m, busy); end
  endtask

  task automatic test_error();
    push(4'd7, 11'd9);
    wait_bready();
    b_resp(32'h0, 2'b11);
    n_cmp++; if (err_vld !== 1'b1 || err_hart !== 4'd7) begin n_bad++; $display("FAIL err_resp got vld=%b hart=%0d want 1 7", err_vld, err_hart); end
    tick();
    n_cmp++; if (err_vld !== 1'b0 || err_hart !== 4'd7) begin n_bad++; $display("FAIL err_pulse got vld=%b hart=%0d want 0 7", err_vld, err_hart); end
    push(4'd6, 11'd4);
    wait_bready();
    b_resp(32'h1, 2'b00);
    n_cmp++; if (err_vld !== 1'b1 || err_hart !== 4'd6) begin n_bad++; $display("FAIL err_id got vld=%b hart=%0d want 1 6", err_vld, err_hart); end
    tick();
    n_cmp++; if (err_vld !== 1'b0) begin n_bad++; $display("FAIL err_id_pulse got vld=%b want 0", err_vld); end
  endtask

  task automatic test_eiid0();
    req_vld = 1'b1; req_hart = 4'd2; req_eiid = 11'd0;
    n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL eiid0_rdy got %b want 1", req_rdy); end
    tick();
    req_vld = 1'b0; req_hart = '0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (awvalid_m !== 1'b0 || wvalid_m !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL eiid0_idle%0d got awv=%b wv=%b busy=%b want 0 0 0", c, awvalid_m, wvalid_m, busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    awready_m = 1'b0; wready_m = 1'b0;
    push(4'd1, 11'd1);
    push(4'd2, 11'd2);
    n_cmp++; if (awvalid_m !== 1'b1) begin n_bad++; $display("FAIL rst_pre got awv=%b want 1", awvalid_m); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (awvalid_m !== 1'b0 || wvalid_m !== 1'b0 || busy !== 1'b0 || req_rdy !== 1'b1) begin
      n_bad++; $display("FAIL rst_async got awv=%b wv=%b busy=%b rdy=%b want 0 0 0 1", awvalid_m, wvalid_m, busy, req_rdy);
    end
    @(posedge clk); #1; rstn = 1'b1;
    awready_m = 1'b1; wready_m = 1'b1;
    tick();
    n_cmp++; if (awvalid_m !== 1'b0 || busy !== 1'b0 || err_vld !== 1'b0) begin n_bad++; $display("FAIL rst_after got awv=%b busy=%b err=%b want 0 0 0", awvalid_m, busy, err_vld); end
    push(4'd4, 11'd8);
    tick();
    n_cmp++; if (awvalid_m !== 1'b1 || awaddr_m !== 32'h2400_4000 || wdata_m !== 32'h8) begin n_bad++; $display("FAIL rst_next got awv=%b addr=%h data=%h want 1 24004000 00000008", awvalid_m, awaddr_m, wdata_m); end
    wait_bready();
    b_resp(32'h0, 2'b00);
    tick();
    n_cmp++; if (busy !== 1'b0 || err_vld !== 1'b0) begin n_bad++; $display("FAIL rst_end got busy=%b err=%b want 0 0", busy, err_vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fifo_fill();
    test_error();
    test_eiid0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imsic_msi_tx_axi.md
Name: imsic_msi_tx_axi

Overview:
- AXI4-lite write master that delivers MSIs to IMSIC interrupt files. It is the transmit end of the IMSIC MSI write port.
- Sits in the interrupt source domain (APLIC MSI-mode delivery, test MSI generators). Accepts {hart index, EIID} requests into a small FIFO.
- Turns each request into one AXI write: address = BASE_ADDR + hart × 4 KiB, data = EIID.
- Waits for the B response before issuing the next write, and reports error responses.

Parameters:
AXI_ID_WIDTH, 32, width of awid_m/bid_m
AXI_ADDR_WIDTH, 32, width of awaddr_m
HART_IDX_WIDTH, 4, width of req_hart
FIFO_DEPTH, 4, request FIFO entries; power of 2, >=2
BASE_ADDR, 32'h2400_0000, address of interrupt file 0 (AXI_ADDR_WIDTH bits)
TX_AXI_ID, 0, constant ID driven on awid_m and expected on bid_m

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_vld  in  1  MSI request valid
req_rdy  out  1  request accepted when req_vld&req_rdy
req_hart  in  HART_IDX_WIDTH  target interrupt-file index
req_eiid  in  11  external interrupt identity
awvalid_m  out  1  AW valid
awready_m  in  1  AW ready
awaddr_m  out  AXI_ADDR_WIDTH  write address
awid_m  out  AXI_ID_WIDTH  write ID, always TX_AXI_ID
wvalid_m  out  1  W valid
wready_m  in  1  W ready
wdata_m  out  32  {21'b0, eiid}
bvalid_m  in  1  B valid
bready_m  out  1  B ready
bid_m  in  AXI_ID_WIDTH  response ID
bresp_m  in  2  response code
err_vld  out  1  one-cycle pulse: write failed
err_hart  out  HART_IDX_WIDTH  hart index of the failed write
busy  out  1  FIFO non-empty or transaction in flight

Behaviour:
- Reset (rstn low, asynchronous):
  - FIFO cleared, FSM to IDLE.
  - awvalid_m, wvalid_m, bready_m, err_vld = 0; awaddr_m, wdata_m, err_hart = 0.
  - awid_m is constant TX_AXI_ID.
  - Reset mid-transaction abandons the write; no error is reported.
- Request FIFO:
  - req_rdy = (count != FIFO_DEPTH), combinational from registered count.
  - A push (req_vld&req_rdy) with req_eiid != 0 enqueues {hart, eiid}.
  - A push with req_eiid == 0 is accepted and dropped, since identity 0 is invalid.
  - Push and pop in the same cycle are allowed; count is unchanged and order is preserved.
  - A full FIFO never accepts, even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, SEND, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head and register awaddr_m = BASE_ADDR + (hart << 12) and wdata_m = {21'b0, eiid}.
  - In the same edge, set awvalid_m = wvalid_m = 1 and go to SEND.
  - Latency: push at cycle N into an empty FIFO while IDLE gives awvalid_m/wvalid_m high at N+2.
- SEND:
  - awvalid_m clears on the edge after awvalid_m&awready_m; wvalid_m clears on the edge after wvalid_m&wready_m. The two channels are independent.
  - awaddr_m and wdata_m stay stable while their valid is high.
  - When both handshakes have completed (same cycle or different cycles), go to RESP with bready_m = 1 on the next cycle.
  - bready_m is 0 in SEND; a bvalid_m in SEND is not consumed.
- RESP:
  - bready_m = 1. On bvalid_m&bready_m, go to IDLE and drop bready_m.
  - If bresp_m != 2'b00 or bid_m != TX_AXI_ID: err_vld = 1 for exactly one cycle (the cycle after the handshake), with err_hart = the transaction's hart.
  - err_hart holds its value until the next error.
  - At most one outstanding write; the next pop happens in IDLE the cycle after the B handshake.
- busy = (state != IDLE) | (count != 0).
- Address arithmetic: the hart index is zero-extended to AXI_ADDR_WIDTH before the shift; the sum wraps modulo 2^AXI_ADDR_WIDTH.

Test Plan:
1. Single request, hart=3, eiid=5, AW/W ready tied high: push at N -> awvalid_m & wvalid_m at N+2, awaddr_m=0x2400_3000, wdata_m=0x5; then bresp=0 -> no err_vld, busy low two cycles after the B handshake.
2. Back-pressure, wready_m immediate, awready_m delayed 3 cycles: wvalid_m drops first, awvalid_m holds with a stable address; bready_m rises only after both handshakes; then swap the delays -> same result.
3. FIFO fill: awready_m=0, push 5 requests (hart 0..4, eiid 1..5) -> first popped into SEND, next 4 fill the FIFO, req_rdy=0 on the 6th push; release awready_m -> writes issue in order to 0x2400_0000..0x2400_4000 with one outstanding at a time.
4. Error response: hart=7, eiid=9, bresp_m=2'b11 -> err_vld a single-cycle pulse with err_hart=7; second case bid_m=1 with bresp_m=0 -> err_vld pulse.
5. eiid=0 push: req_rdy=1, the request is accepted, no AXI activity, busy stays 0.
6. Reset asserted in SEND with awvalid_m high: all valids drop immediately, FIFO empties, req_rdy=1 after release; the next request issues normally.
